register_file_sb: RTL and testbench

Parametrised integer register file for the RISC-V core: one synchronous write port, NRD combinational read ports, optional write-to-read bypass, and a per-register scoreboard of pending writes. It sits between decode/issue, which reads operands and marks destinations, and writeback, which writes results and retires pending marks. The issue stage uses o_rbusy/o_waw to generate pipeline stalls.

---
 rtl/register_file_sb_if.sv | 40 ++++
 rtl/register_file_sb.sv | 88 ++++++++
 tb/tb_register_file_sb.sv | 246 ++++++++++++++++++++++++
 3 files changed

// File: rtl/register_file_sb_if.sv
// register_file_sb_if
//   Bus between issue/writeback and the integer register file.
//   master : pipeline side (drives writeback, read addresses, issue, flush)
//   slave  : register file side (returns read data, busy flags, hazards)
//   Signals:
//     i_reg_write, i_addr_des, i_data   writeback port
//     i_raddr / o_rdata / o_rbusy       NRD packed read ports
//     i_issue_valid, i_issue_rd, o_waw  issue-side scoreboard marking
//     i_flush, o_pending                scoreboard clear / any-busy summary
interface register_file_sb_if #(
    parameter int XLEN = 32,
    parameter int NREG = 32,
    parameter int NRD  = 2
);
    localparam int AW = $clog2(NREG);

    logic                 i_reg_write;
    logic [AW-1:0]        i_addr_des;
    logic [XLEN-1:0]      i_data;
    logic [NRD*AW-1:0]    i_raddr;
    logic [NRD*XLEN-1:0]  o_rdata;
    logic [NRD-1:0]       o_rbusy;
    logic                 i_issue_valid;
    logic [AW-1:0]        i_issue_rd;
    logic                 o_waw;
    logic                 i_flush;
    logic                 o_pending;

    modport master (
        output i_reg_write, i_addr_des, i_data, i_raddr,
        output i_issue_valid, i_issue_rd, i_flush,
        input  o_rdata, o_rbusy, o_waw, o_pending
    );

    modport slave (
        input  i_reg_write, i_addr_des, i_data, i_raddr,
        input  i_issue_valid, i_issue_rd, i_flush,
        output o_rdata, o_rbusy, o_waw, o_pending
    );
endinterface

// File: rtl/register_file_sb.sv
// register_file_sb
//   Integer register file with one synchronous write port, NRD combinational
//   read ports, optional same-cycle write-to-read bypass and a per-register
//   scoreboard of outstanding writes used by issue for stall generation.
//   Ports:
//     i_clk    clock, all state updates on rising edge
//     i_rst_n  asynchronous active-low reset (clears data and scoreboard)
//     bus      register_file_sb_if.slave (writeback, reads, issue, flush)
module register_file_sb #(
    parameter int XLEN     = 32,
    parameter int NREG     = 32,
    parameter int NRD      = 2,
    parameter int BYPASS   = 1,
    parameter int ZERO_REG = 1
) (
    input  logic               i_clk,
    input  logic               i_rst_n,
    register_file_sb_if.slave  bus
);
    localparam int AW = $clog2(NREG);

    logic [XLEN-1:0]     regs [NREG];
    logic [NREG-1:0]     busy;
    logic [NREG-1:0]     busy_nxt;
    logic                write_en;
    logic [NRD*XLEN-1:0] rdata_c;
    logic [NRD-1:0]      rbusy_c;

    assign write_en = bus.i_reg_write &&
                      !((ZERO_REG != 0) && (bus.i_addr_des == '0));

    // Issue is applied after writeback clear so a newer producer marking the
    // same register keeps it busy.
    always_comb begin
        busy_nxt = busy;
        if (bus.i_flush) begin
            busy_nxt = '0;
        end else begin
            if (bus.i_reg_write)
                busy_nxt[bus.i_addr_des] = 1'b0;
            if (bus.i_issue_valid)
                busy_nxt[bus.i_issue_rd] = 1'b1;
        end
        if (ZERO_REG != 0)
            busy_nxt[0] = 1'b0;
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int r = 0; r < NREG; r++)
                regs[r] <= '0;
            busy <= '0;
        end else begin
            if (write_en)
                regs[bus.i_addr_des] <= bus.i_data;
            busy <= busy_nxt;
        end
    end

    // Read data is forced to zero during reset because the bypass path would
    // otherwise leak i_data straight through.
    always_comb begin
        rdata_c = '0;
        rbusy_c = '0;
        for (int k = 0; k < NRD; k++) begin
            logic [AW-1:0] ra;
            logic          hit;
            logic          zr;
            ra  = bus.i_raddr[k*AW +: AW];
            hit = (BYPASS != 0) && bus.i_reg_write && (bus.i_addr_des == ra);
            zr  = (ZERO_REG != 0) && (ra == '0);
            if (!i_rst_n || zr)
                rdata_c[k*XLEN +: XLEN] = '0;
            else if (hit)
                rdata_c[k*XLEN +: XLEN] = bus.i_data;
            else
                rdata_c[k*XLEN +: XLEN] = regs[ra];
            rbusy_c[k] = busy[ra] && !hit && !zr;
        end
    end

    assign bus.o_rdata   = rdata_c;
    assign bus.o_rbusy   = rbusy_c;
    assign bus.o_waw     = bus.i_issue_valid && busy[bus.i_issue_rd] &&
                           !(bus.i_reg_write && (bus.i_addr_des == bus.i_issue_rd)) &&
                           !((ZERO_REG != 0) && (bus.i_issue_rd == '0));
    assign bus.o_pending = |busy;
endmodule

// File: tb/tb_register_file_sb.sv
module tb_register_file_sb;
    localparam int XLEN = 32;
    localparam int NREG = 32;
    localparam int NRD  = 2;
    localparam int AW   = 5;

    logic i_clk;
    logic i_rst_n;
    int   n_total = 0;
    int   n_bad   = 0;

    register_file_sb_if #(.XLEN(XLEN), .NREG(NREG), .NRD(NRD)) bus ();

    register_file_sb #(
        .XLEN(XLEN), .NREG(NREG), .NRD(NRD), .BYPASS(1), .ZERO_REG(1)
    ) dut (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .bus     (bus)
    );

    initial begin
        i_clk = 1'b0;
        forever #5 i_clk = ~i_clk;
    end

    // Reference: architectural contents and set of outstanding destinations.
    logic [XLEN-1:0] m_regs [NREG];
    bit              m_busy [NREG];

    task automatic check_val(input string tag, input logic [XLEN-1:0] obs,
                             input logic [XLEN-1:0] exp);
        n_total++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [XLEN-1:0] exp_rdata(input int a);
        if (a == 0) return '0;
        if (bus.i_reg_write && int'(bus.i_addr_des) == a) return bus.i_data;
        return m_regs[a];
    endfunction

    function automatic logic exp_rbusy(input int a);
        if (a == 0) return 1'b0;
        if (bus.i_reg_write && int'(bus.i_addr_des) == a) return 1'b0;
        return m_busy[a];
    endfunction

    function automatic logic exp_pending();
        for (int r = 0; r < NREG; r++)
            if (m_busy[r]) return 1'b1;
        return 1'b0;
    endfunction

    function automatic logic exp_waw();
        int rd;
        rd = int'(bus.i_issue_rd);
        if (!bus.i_issue_valid || rd == 0) return 1'b0;
        if (bus.i_reg_write && int'(bus.i_addr_des) == rd) return 1'b0;
        return m_busy[rd];
    endfunction

    task automatic model_reset();
        for (int r = 0; r < NREG; r++) begin
            m_regs[r] = '0;
            m_busy[r] = 1'b0;
        end
    endtask

    // Applies the inputs held across the rising edge to the reference.
    task automatic model_edge();
        int ad;
        ad = int'(bus.i_addr_des);
        if (bus.i_reg_write && ad != 0) m_regs[ad] = bus.i_data;
        if (bus.i_flush) begin
            for (int r = 0; r < NREG; r++) m_busy[r] = 1'b0;
        end else begin
            if (bus.i_reg_write) m_busy[ad] = 1'b0;
            if (bus.i_issue_valid && bus.i_issue_rd != 0) m_busy[int'(bus.i_issue_rd)] = 1'b1;
        end
    endtask

    task automatic compare_all();
        for (int k = 0; k < NRD; k++) begin
            int a;
            a = int'(bus.i_raddr[k*AW +: AW]);
            check_val($sformatf("rdata%0d[x%0d]", k, a), bus.o_rdata[k*XLEN +: XLEN], exp_rdata(a));
            check_val($sformatf("rbusy%0d[x%0d]", k, a), XLEN'(bus.o_rbusy[k]), XLEN'(exp_rbusy(a)));
        end
        check_val("waw", XLEN'(bus.o_waw), XLEN'(exp_waw()));
        check_val("pending", XLEN'(bus.o_pending), XLEN'(exp_pending()));
    endtask

    task automatic idle();
        bus.i_reg_write   = 1'b0;
        bus.i_addr_des    = '0;
        bus.i_data        = '0;
        bus.i_issue_valid = 1'b0;
        bus.i_issue_rd    = '0;
        bus.i_flush       = 1'b0;
    endtask

    task automatic set_rd(input int a0, input int a1);
        bus.i_raddr = {AW'(a1), AW'(a0)};
    endtask

    task automatic settle();
        #1;
        compare_all();
    endtask

    task automatic advance();
        @(posedge i_clk);
        model_edge();
        @(negedge i_clk);
        idle();
    endtask

    initial begin
        i_rst_n = 1'b0;
        idle();
        set_rd(0, 0);
        model_reset();
        repeat (2) @(negedge i_clk);
        set_rd(5, 31);
        bus.i_reg_write = 1'b1;
        bus.i_addr_des  = 5'd5;
        bus.i_data      = 32'hFFFF_FFFF;
        #1;
        check_val("rst_rdata0", bus.o_rdata[31:0], 32'h0);
        check_val("rst_rbusy", XLEN'(bus.o_rbusy), 32'h0);
        check_val("rst_pending", XLEN'(bus.o_pending), 32'h0);
        @(negedge i_clk);
        idle();
        i_rst_n = 1'b1;

        // Post-reset reads
        set_rd(0, 5);   settle(); advance();
        set_rd(31, 31); settle();
        check_val("init_x31", bus.o_rdata[31:0], 32'h0);
        advance();

        // Bypass of x7 then array read
        set_rd(7, 7);
        bus.i_reg_write = 1'b1; bus.i_addr_des = 5'd7; bus.i_data = 32'hDEAD_BEEF;
        settle();
        check_val("byp_x7", bus.o_rdata[31:0], 32'hDEAD_BEEF);
        advance();
        settle();
        check_val("arr_x7", bus.o_rdata[63:32], 32'hDEAD_BEEF);
        advance();

        // x0 hardwired and never busy
        set_rd(0, 0);
        bus.i_reg_write = 1'b1; bus.i_addr_des = 5'd0; bus.i_data = 32'h1234_5678;
        bus.i_issue_valid = 1'b1; bus.i_issue_rd = 5'd0;
        settle();
        check_val("x0_waw", XLEN'(bus.o_waw), 32'h0);
        advance();
        settle();
        check_val("x0_data", bus.o_rdata[31:0], 32'h0);
        check_val("x0_busy", XLEN'(bus.o_rbusy[0]), 32'h0);
        advance();

        // Scoreboard on x3
        set_rd(3, 7);
        bus.i_issue_valid = 1'b1; bus.i_issue_rd = 5'd3;
        settle(); advance();
        bus.i_issue_valid = 1'b1; bus.i_issue_rd = 5'd3;
        settle();
        check_val("x3_busy", XLEN'(bus.o_rbusy[0]), 32'h1);
        check_val("x3_pend", XLEN'(bus.o_pending), 32'h1);
        check_val("x3_waw", XLEN'(bus.o_waw), 32'h1);
        advance();
        bus.i_issue_valid = 1'b1; bus.i_issue_rd = 5'd3;
        bus.i_reg_write = 1'b1; bus.i_addr_des = 5'd3; bus.i_data = 32'hA5;
        settle();
        check_val("x3_wb_waw", XLEN'(bus.o_waw), 32'h0);
        advance();
        settle();
        check_val("x3_still_busy", XLEN'(bus.o_rbusy[0]), 32'h1);
        check_val("x3_data", bus.o_rdata[31:0], 32'hA5);
        advance();

        // Issue 4,5,6 then flush with a concurrent issue of 9
        for (int r = 4; r <= 6; r++) begin
            set_rd(r, 3);
            bus.i_issue_valid = 1'b1; bus.i_issue_rd = AW'(r);
            settle(); advance();
        end
        set_rd(9, 4);
        bus.i_flush = 1'b1; bus.i_issue_valid = 1'b1; bus.i_issue_rd = 5'd9;
        settle(); advance();
        settle();
        check_val("flush_pend", XLEN'(bus.o_pending), 32'h0);
        check_val("flush_x9", XLEN'(bus.o_rbusy[0]), 32'h0);
        set_rd(7, 3);
        #1;
        check_val("flush_x7", bus.o_rdata[31:0], 32'hDEAD_BEEF);
        check_val("flush_x3", bus.o_rdata[63:32], 32'hA5);
        advance();

        // Randomized traffic
        for (int c = 0; c < 600; c++) begin
            int a0, a1;
            bus.i_reg_write   = ($urandom_range(0, 1) == 1);
            bus.i_addr_des    = AW'($urandom_range(0, NREG - 1));
            bus.i_data        = $urandom;
            bus.i_issue_valid = ($urandom_range(0, 2) == 0);
            bus.i_issue_rd    = ($urandom_range(0, 1) == 1) ? bus.i_addr_des
                                                            : AW'($urandom_range(0, NREG - 1));
            bus.i_flush       = ($urandom_range(0, 40) == 0);
            a0 = ($urandom_range(0, 1) == 1) ? int'(bus.i_addr_des) : int'($urandom_range(0, NREG - 1));
            a1 = ($urandom_range(0, 3) == 0) ? a0 : int'($urandom_range(0, NREG - 1));
            set_rd(a0, a1);
            settle();
            advance();
        end

        // Asynchronous reset between edges
        set_rd(10, 11);
        bus.i_reg_write = 1'b1; bus.i_addr_des = 5'd10; bus.i_data = 32'h55;
        bus.i_issue_valid = 1'b1; bus.i_issue_rd = 5'd11;
        settle(); advance();
        settle();
        check_val("pre_rst_x10", bus.o_rdata[31:0], 32'h55);
        check_val("pre_rst_x11", XLEN'(bus.o_rbusy[1]), 32'h1);
        #2;
        i_rst_n = 1'b0;
        model_reset();
        #1;
        check_val("arst_x10", bus.o_rdata[31:0], 32'h0);
        check_val("arst_x11", XLEN'(bus.o_rbusy[1]), 32'h0);
        check_val("arst_pend", XLEN'(bus.o_pending), 32'h0);
        @(negedge i_clk);
        i_rst_n = 1'b1;
        settle();
        advance();

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end
endmodule
